mult_div_ctrl: RTL and testbench

Sequencer for the HI/LO multiply/divide resource in the EX stage. It takes the ALU funct code produced in ID, along with the two EX operands. It runs iterative MULT/MULTU/DIV/DIVU operations, owns the HI and LO registers, and services MFHI/MFLO/MTHI/MTLO. While an iterative operation is in flight, it raises a stall request to the pipeline controller.

---
 rtl/mult_div_ctrl_if.sv | 26 ++
 rtl/mult_div_ctrl.sv | 247 ++++++++++++++++++++++++
 tb/tb_mult_div_ctrl.sv | 261 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/mult_div_ctrl_if.sv
// Bundle between the EX stage and the HI/LO multiply/divide sequencer.
// The pipeline side uses the master modport, the sequencer the slave modport.
interface mult_div_ctrl_if #(
    parameter int DATA_WIDTH = 32
);
    logic [5:0]            funct;
    logic [DATA_WIDTH-1:0] operand_1;
    logic [DATA_WIDTH-1:0] operand_2;
    logic                  flush;
    logic                  hold;
    logic                  stall_request;
    logic                  busy;
    logic [DATA_WIDTH-1:0] hi;
    logic [DATA_WIDTH-1:0] lo;
    logic [DATA_WIDTH-1:0] result;

    modport master (
        output funct, operand_1, operand_2, flush, hold,
        input  stall_request, busy, hi, lo, result
    );

    modport slave (
        input  funct, operand_1, operand_2, flush, hold,
        output stall_request, busy, hi, lo, result
    );
endinterface

// File: rtl/mult_div_ctrl.sv
// HI/LO multiply/divide sequencer for the EX stage.
// Runs MULT/MULTU as a 32-step shift-add and DIV/DIVU as a 32-step restoring
// divide on unsigned magnitudes, fixing the signs up in the final step. It
// owns HI/LO, services MFHI/MFLO/MTHI/MTLO, and stalls IF..EX while busy.
// Optional feature macro: MULT_DIV_FAST_MULT_EN -- when defined, MULT/MULTU
// complete in the IDLE cycle through a combinational multiplier (no stall).
module mult_div_ctrl #(
    parameter int DATA_WIDTH = 32
) (
    input  logic               clk,
    input  logic               rst,
    mult_div_ctrl_if.slave     bus
);
    localparam int W  = DATA_WIDTH;
    localparam int W2 = 2 * DATA_WIDTH;

    localparam logic [5:0] F_MFHI  = 6'h10;
    localparam logic [5:0] F_MTHI  = 6'h11;
    localparam logic [5:0] F_MFLO  = 6'h12;
    localparam logic [5:0] F_MTLO  = 6'h13;
    localparam logic [5:0] F_MULT  = 6'h18;
    localparam logic [5:0] F_MULTU = 6'h19;
    localparam logic [5:0] F_DIV   = 6'h1A;
    localparam logic [5:0] F_DIVU  = 6'h1B;

    localparam logic [4:0] CNT_LAST = 5'(W - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    // Two's-complement negate of a word when n is set.
    function automatic logic [W-1:0] neg_if_w(input logic [W-1:0] v, input logic n);
        logic [W-1:0] r;
        r = n ? ((~v) + W'(1)) : v;
        return r;
    endfunction

    // Two's-complement negate of a double word when n is set.
    function automatic logic [W2-1:0] neg_if_w2(input logic [W2-1:0] v, input logic n);
        logic [W2-1:0] r;
        r = n ? ((~v) + W2'(1)) : v;
        return r;
    endfunction

    // Unsigned magnitude; for the most negative value this yields 2^(W-1).
    function automatic logic [W-1:0] mag(input logic [W-1:0] v, input logic sgn);
        return neg_if_w(v, sgn & v[W-1]);
    endfunction

    // One shift-add step: acc = {partial product, unconsumed multiplier bits}.
    function automatic logic [W2-1:0] mul_step(input logic [W2-1:0] acc,
                                               input logic [W-1:0]  mcand);
        logic [W:0] sum;
        sum = {1'b0, acc[W2-1:W]} + (acc[0] ? {1'b0, mcand} : {(W+1){1'b0}});
        return {sum, acc[W-1:1]};
    endfunction

    // One restoring-divide step: acc = {remainder, dividend/quotient bits}.
    // The trial value spans W+1 bits because the shifted remainder can exceed
    // W bits; a set MSB of the difference means "would go negative".
    // A zero divisor naturally yields an all-ones quotient and the dividend
    // as remainder.
    function automatic logic [W2-1:0] div_step(input logic [W2-1:0] acc,
                                               input logic [W-1:0]  dvs);
        logic [W:0]    trial;
        logic [W2-1:0] r;
        trial = acc[W2-1:W-1] - {1'b0, dvs};
        if (trial[W]) r = {acc[W2-2:0], 1'b0};
        else          r = {trial[W-1:0], acc[W-2:0], 1'b1};
        return r;
    endfunction

    // Sign fix-up of the raw magnitude result, returned as {hi, lo}.
    // Signed 0x8000_0000 / -1 falls out as quotient 0x8000_0000, remainder 0.
    function automatic logic [W2-1:0] finish(input logic [W2-1:0] acc,
                                             input logic          is_div,
                                             input logic          neg_lo,
                                             input logic          neg_hi,
                                             input logic [W-1:0]  dvs);
        logic [W2-1:0] r;
        logic [W-1:0]  q_fix;
        logic [W-1:0]  r_fix;
        if (!is_div) begin
            r = neg_if_w2(acc, neg_lo);
        end else begin
            r_fix = neg_if_w(acc[W2-1:W], neg_hi);
            q_fix = (dvs == '0) ? '1 : neg_if_w(acc[W-1:0], neg_lo);
            r     = {r_fix, q_fix};
        end
        return r;
    endfunction

    // Funct codes that occupy the iterative datapath.
    function automatic logic is_iter(input logic [5:0] f);
`ifdef MULT_DIV_FAST_MULT_EN
        return (f == F_DIV) || (f == F_DIVU);
`else
        return (f == F_MULT) || (f == F_MULTU) || (f == F_DIV) || (f == F_DIVU);
`endif
    endfunction

`ifdef MULT_DIV_FAST_MULT_EN
    // Single-cycle product, returned as {hi, lo}.
    function automatic logic [W2-1:0] fast_mul(input logic [W-1:0] a,
                                               input logic [W-1:0] b,
                                               input logic         sgn);
        logic [W2-1:0] p;
        p = W2'(mag(a, sgn)) * W2'(mag(b, sgn));
        return neg_if_w2(p, sgn & (a[W-1] ^ b[W-1]));
    endfunction
`endif

    state_t         state_q, state_d;
    logic [4:0]     cnt_q, cnt_d;
    logic [W2-1:0]  acc_q, acc_d;
    logic [W-1:0]   opb_q, opb_d;
    logic           is_div_q, is_div_d;
    logic           neg_lo_q, neg_lo_d;
    logic           neg_hi_q, neg_hi_d;
    logic [W-1:0]   hi_q, hi_d;
    logic [W-1:0]   lo_q, lo_d;

    logic           op_signed;
    logic           op_div;
    logic [W-1:0]   mag_1;
    logic [W-1:0]   mag_2;
    logic [W2-1:0]  acc_step;
    logic [W2-1:0]  final_res;
    logic           stall_req;
    logic [W-1:0]   result_c;

    assign op_signed = (bus.funct == F_MULT) || (bus.funct == F_DIV);
    assign op_div    = (bus.funct == F_DIV) || (bus.funct == F_DIVU);
    assign mag_1     = mag(bus.operand_1, op_signed);
    assign mag_2     = mag(bus.operand_2, op_signed);
    assign acc_step  = is_div_q ? div_step(acc_q, opb_q) : mul_step(acc_q, opb_q);
    assign final_res = finish(acc_step, is_div_q, neg_lo_q, neg_hi_q, opb_q);

    // State register and datapath flops.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            acc_q    <= '0;
            opb_q    <= '0;
            is_div_q <= 1'b0;
            neg_lo_q <= 1'b0;
            neg_hi_q <= 1'b0;
            hi_q     <= '0;
            lo_q     <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            acc_q    <= acc_d;
            opb_q    <= opb_d;
            is_div_q <= is_div_d;
            neg_lo_q <= neg_lo_d;
            neg_hi_q <= neg_hi_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
        end
    end

    // Next-state, iteration and HI/LO write logic; flush overrides everything.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        acc_d    = acc_q;
        opb_d    = opb_q;
        is_div_d = is_div_q;
        neg_lo_d = neg_lo_q;
        neg_hi_d = neg_hi_q;
        hi_d     = hi_q;
        lo_d     = lo_q;

        unique case (state_q)
            IDLE: begin
                if (is_iter(bus.funct)) begin
                    // Divide keeps the dividend in the low half; multiply keeps
                    // the multiplier there and the multiplicand in opb.
                    is_div_d = op_div;
                    acc_d    = op_div ? {{W{1'b0}}, mag_1} : {{W{1'b0}}, mag_2};
                    opb_d    = op_div ? mag_2 : mag_1;
                    neg_lo_d = op_signed & (bus.operand_1[W-1] ^ bus.operand_2[W-1]);
                    neg_hi_d = op_signed & bus.operand_1[W-1];
                    cnt_d    = '0;
                    state_d  = BUSY;
                end else if (bus.funct == F_MTHI) begin
                    hi_d = bus.operand_1;
                end else if (bus.funct == F_MTLO) begin
                    lo_d = bus.operand_1;
`ifdef MULT_DIV_FAST_MULT_EN
                end else if ((bus.funct == F_MULT) || (bus.funct == F_MULTU)) begin
                    {hi_d, lo_d} = fast_mul(bus.operand_1, bus.operand_2, op_signed);
`endif
                end
            end
            BUSY: begin
                acc_d = acc_step;
                cnt_d = cnt_q + 5'd1;
                if (cnt_q == CNT_LAST) begin
                    {hi_d, lo_d} = final_res;
                    state_d      = DONE;
                end
            end
            DONE: begin
                if (!bus.hold) state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (bus.flush) begin
            state_d = IDLE;
            cnt_d   = '0;
            hi_d    = hi_q;
            lo_d    = lo_q;
        end
    end

    // Stall request: freeze the front end while an iterative op is accepted or running.
    always_comb begin
        stall_req = 1'b0;
        unique case (state_q)
            IDLE:    stall_req = is_iter(bus.funct) && !bus.flush;
            BUSY:    stall_req = 1'b1;
            default: stall_req = 1'b0;
        endcase
    end

    // MFHI/MFLO read port.
    always_comb begin
        result_c = '0;
        if (bus.funct == F_MFHI)      result_c = hi_q;
        else if (bus.funct == F_MFLO) result_c = lo_q;
    end

    assign bus.stall_request = stall_req;
    assign bus.busy          = (state_q != IDLE);
    assign bus.hi            = hi_q;
    assign bus.lo            = lo_q;
    assign bus.result        = result_c;
endmodule

// File: tb/tb_mult_div_ctrl.sv
// Randomized self-checking bench for mult_div_ctrl with an arithmetic
// reference model of HI/LO and a fixed 33-cycle stall expectation.
module tb_mult_div_ctrl;
    localparam logic [5:0] F_NOP   = 6'h00;
    localparam logic [5:0] F_MFHI  = 6'h10;
    localparam logic [5:0] F_MTHI  = 6'h11;
    localparam logic [5:0] F_MFLO  = 6'h12;
    localparam logic [5:0] F_MTLO  = 6'h13;
    localparam logic [5:0] F_MULT  = 6'h18;
    localparam logic [5:0] F_MULTU = 6'h19;
    localparam logic [5:0] F_DIV   = 6'h1A;
    localparam logic [5:0] F_DIVU  = 6'h1B;

    logic clk = 1'b0;
    logic rst = 1'b1;

    mult_div_ctrl_if #(.DATA_WIDTH(32)) bus ();

    mult_div_ctrl #(.DATA_WIDTH(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_pass   = 0;
    logic [31:0] exp_hi   = '0;
    logic [31:0] exp_lo   = '0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    // Architectural effect of one instruction on HI/LO.
    task automatic ref_exec(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b);
        longint      sa, sb, sp;
        logic [63:0] up;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        case (f)
            F_MTHI:  exp_hi = a;
            F_MTLO:  exp_lo = a;
            F_MULT:  begin sp = sa * sb; {exp_hi, exp_lo} = sp; end
            F_MULTU: begin up = {32'b0, a} * {32'b0, b}; {exp_hi, exp_lo} = up; end
            F_DIV: begin
                if (b == 0) begin exp_lo = '1; exp_hi = a; end
                else begin sp = sa / sb; exp_lo = sp[31:0]; sp = sa % sb; exp_hi = sp[31:0]; end
            end
            F_DIVU: begin
                if (b == 0) begin exp_lo = '1; exp_hi = a; end
                else begin exp_lo = a / b; exp_hi = a % b; end
            end
            default: ;
        endcase
    endtask

    // Issue one iterative op at posedge+1; returns at posedge+1 of the IDLE cycle after DONE.
    task automatic run_op(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b);
        int n;
        ref_exec(f, a, b);
        bus.funct     = f;
        bus.operand_1 = a;
        bus.operand_2 = b;
        n = 0;
        @(negedge clk);
        while (bus.stall_request && n < 60) begin
            n++;
            @(negedge clk);
        end
        chk("stall_cycles", 64'(n), 64'd33);
        chk("done_busy", bus.busy, 1'b1);
        chk("op_hi", bus.hi, exp_hi);
        chk("op_lo", bus.lo, exp_lo);
        @(posedge clk);
        #1;
        bus.funct = F_NOP;
    endtask

    function automatic logic [31:0] pick(input logic allow_edge);
        logic [31:0] edges [5];
        edges[0] = 32'h0000_0000;
        edges[1] = 32'h0000_0001;
        edges[2] = 32'hFFFF_FFFF;
        edges[3] = 32'h8000_0000;
        edges[4] = 32'h7FFF_FFFF;
        if (allow_edge && ($urandom_range(0, 3) == 0)) return edges[$urandom_range(0, 4)];
        return $urandom();
    endfunction

    initial begin
        logic [5:0] ops [4];
        int         n;
        ops[0] = F_MULT; ops[1] = F_MULTU; ops[2] = F_DIV; ops[3] = F_DIVU;

        bus.funct     = F_NOP;
        bus.operand_1 = '0;
        bus.operand_2 = '0;
        bus.flush     = 1'b0;
        bus.hold      = 1'b0;

        // Reset state
        #2;
        bus.funct = F_MFHI;
        #1;
        chk("rst_result_mfhi", bus.result, 32'h0);
        chk("rst_hi", bus.hi, 32'h0);
        chk("rst_lo", bus.lo, 32'h0);
        chk("rst_busy", bus.busy, 1'b0);
        chk("rst_stall", bus.stall_request, 1'b0);
        bus.funct = F_MFLO;
        #1;
        chk("rst_result_mflo", bus.result, 32'h0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
        bus.funct = F_MFHI;
        @(negedge clk);
        chk("mfhi_after_rst", bus.result, 32'h0);
        chk("mfhi_stall", bus.stall_request, 1'b0);
        @(posedge clk);
        #1;

        // Directed arithmetic corners, issued back to back
        run_op(F_MULTU, 32'hFFFF_FFFF, 32'h2);
        run_op(F_MULT,  32'hFFFF_FFFD, 32'h5);
        run_op(F_DIV,   32'hFFFF_FFF9, 32'h2);
        bus.funct = F_MFLO;
        @(negedge clk);
        chk("mflo_after_div", bus.result, exp_lo);
        @(posedge clk);
        #1;
        run_op(F_DIVU,  32'h7, 32'h0);
        run_op(F_DIV,   32'h8000_0000, 32'hFFFF_FFFF);
        run_op(F_DIV,   32'h8000_0000, 32'h0);

        // MTHI then MFHI, MTLO suppressed by flush
        bus.funct = F_MTHI;
        bus.operand_1 = 32'h1234_5678;
        ref_exec(F_MTHI, 32'h1234_5678, 32'h0);
        @(negedge clk);
        chk("mthi_stall", bus.stall_request, 1'b0);
        @(posedge clk);
        #1;
        bus.funct = F_MFHI;
        @(negedge clk);
        chk("mfhi_result", bus.result, 32'h1234_5678);
        chk("mfhi_no_stall", bus.stall_request, 1'b0);
        @(posedge clk);
        #1;
        bus.funct = F_MTLO;
        bus.operand_1 = 32'hCAFE_F00D;
        bus.flush = 1'b1;
        @(posedge clk);
        #1;
        bus.flush = 1'b0;
        bus.funct = F_MFLO;
        @(negedge clk);
        chk("mtlo_flushed", bus.result, exp_lo);
        @(posedge clk);
        #1;

        // Flush at BUSY cnt=10
        bus.funct = F_DIVU;
        bus.operand_1 = 32'd1000;
        bus.operand_2 = 32'd3;
        @(posedge clk);
        #1;
        repeat (10) @(posedge clk);
        #1;
        bus.flush = 1'b1;
        @(negedge clk);
        chk("flush_cycle_stall", bus.stall_request, 1'b1);
        @(posedge clk);
        #1;
        bus.flush = 1'b0;
        bus.funct = F_NOP;
        @(negedge clk);
        chk("flush_busy", bus.busy, 1'b0);
        chk("flush_stall", bus.stall_request, 1'b0);
        chk("flush_hi", bus.hi, exp_hi);
        chk("flush_lo", bus.lo, exp_lo);
        @(posedge clk);
        #1;
        run_op(F_DIVU, 32'd1000, 32'd3);

        // Completion held in DONE for 3 cycles, funct left on DIVU
        bus.hold = 1'b1;
        ref_exec(F_DIVU, 32'd12345, 32'd17);
        bus.funct = F_DIVU;
        bus.operand_1 = 32'd12345;
        bus.operand_2 = 32'd17;
        n = 0;
        @(negedge clk);
        while (bus.stall_request && n < 60) begin
            n++;
            @(negedge clk);
        end
        chk("hold_stall_cycles", 64'(n), 64'd33);
        chk("hold_lo", bus.lo, exp_lo);
        chk("hold_hi", bus.hi, exp_hi);
        for (int i = 0; i < 3; i++) begin
            chk("hold_done_busy", bus.busy, 1'b1);
            chk("hold_done_stall", bus.stall_request, 1'b0);
            if (i < 2) begin
                @(posedge clk);
                @(negedge clk);
            end
        end
        bus.hold = 1'b0;
        bus.funct = F_NOP;
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("hold_release_busy", bus.busy, 1'b0);
        chk("hold_release_lo", bus.lo, exp_lo);
        @(posedge clk);
        #1;

        // Randomized ops
        for (int k = 0; k < 24; k++) begin
            logic [5:0]  f;
            logic [31:0] a, b;
            f = ops[$urandom_range(0, 3)];
            a = pick(1'b1);
            b = pick(1'b1);
            run_op(f, a, b);
        end

        // Asynchronous reset mid-BUSY
        bus.funct = F_MULTU;
        bus.operand_1 = 32'hDEAD_BEEF;
        bus.operand_2 = 32'h1234_5678;
        @(posedge clk);
        #1;
        repeat (5) @(posedge clk);
        #2;
        rst = 1'b1;
        bus.funct = F_NOP;
        #1;
        chk("arst_hi", bus.hi, 32'h0);
        chk("arst_lo", bus.lo, 32'h0);
        chk("arst_busy", bus.busy, 1'b0);
        chk("arst_stall", bus.stall_request, 1'b0);
        exp_hi = '0;
        exp_lo = '0;
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
        run_op(F_MULT, 32'h7FFF_FFFF, 32'h8000_0000);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
